// File: rtl/z80_wb_arbiter_if.sv
// Bus bundle for the two-master Wishbone arbiter.
// Holds both master-side ports (m0 = Z80 core, m1 = DMA/debug), the shared
// slave bus and the one-hot grant indication. Signal names keep the pin
// names of the arbiter so waveforms read the same as the block diagram.
//   modport slave  : the arbiter's view (takes master requests, drives the shared bus)
//   modport master : the environment's view (masters plus the shared slave)
interface z80_wb_arbiter_if;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [15:0] m0_adr_i;
  logic [7:0]  m0_dat_i;
  logic [1:0]  m0_tga_i;
  logic [7:0]  m0_dat_o;
  logic        m0_ack_o, m0_err_o;

  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [15:0] m1_adr_i;
  logic [7:0]  m1_dat_i;
  logic [1:0]  m1_tga_i;
  logic [7:0]  m1_dat_o;
  logic        m1_ack_o, m1_err_o;

  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [15:0] s_adr_o;
  logic [7:0]  s_dat_o;
  logic [1:0]  s_tga_o;
  logic [7:0]  s_dat_i;
  logic        s_ack_i;

  logic [1:0]  gnt_o;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_tga_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_tga_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_tga_o,
    input  s_dat_i, s_ack_i,
    output gnt_o
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_tga_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_tga_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_tga_o,
    output s_dat_i, s_ack_i,
    input  gnt_o
  );
endinterface

// File: rtl/z80_wb_arbiter.sv
// Two-master Wishbone arbiter with round-robin grant, bus locking and an
// ack watchdog.
//   wb_clk_i   : sole clock, rising edge
//   wb_rst_n_i : asynchronous reset, active low
//   bus        : z80_wb_arbiter_if.slave -- m0 (Z80 core) and m1 (DMA/debug)
//                request ports, shared slave bus, one-hot grant gnt_o
// A grant is held for as long as the owner keeps cyc high; every handover
// passes through one IDLE cycle with the shared bus quiet. If a granted
// strobe waits TIMEOUT cycles without ack, the owner gets a one-cycle err,
// the bus is released and that master is ignored until it drops cyc.
module z80_wb_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd64  // 0 disables the watchdog
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  z80_wb_arbiter_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        last_gnt_q, last_gnt_d;  // 1 = m1 was granted most recently
  logic [7:0]  wd_q, wd_d;              // unacked strobe cycles of the owner
  logic [1:0]  blk_q, blk_d;            // per-master lockout after a timeout

  logic [1:0]  cyc, stb, req;
  logic        granted, sel, expire;

  assign cyc     = {bus.m1_cyc_i, bus.m0_cyc_i};
  assign stb     = {bus.m1_stb_i, bus.m0_stb_i};
  // stb alone never requests; a timed-out master must drop cyc first.
  assign req     = cyc & ~blk_q;
  assign granted = (state_q != IDLE);
  assign sel     = (state_q == GNT1);

  // Expiry fires in the TIMEOUT-th unacked strobe cycle; a same-cycle ack wins.
  assign expire  = granted && (TIMEOUT != 8'd0) && stb[sel] && !bus.s_ack_i &&
                   (wd_q == TIMEOUT - 8'd1);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: begin
        if (req == 2'b11) begin
          state_d    = last_gnt_q ? GNT0 : GNT1;
          last_gnt_d = ~last_gnt_q;
        end else if (req[0]) begin
          state_d    = GNT0;
          last_gnt_d = 1'b0;
        end else if (req[1]) begin
          state_d    = GNT1;
          last_gnt_d = 1'b1;
        end
      end
      GNT0:    if (expire || !cyc[0]) state_d = IDLE;
      GNT1:    if (expire || !cyc[1]) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (!granted || bus.s_ack_i || expire) begin
      wd_d = 8'd0;
    end else if (stb[sel] && (wd_q != 8'hFF)) begin
      wd_d = wd_q + 8'd1;
    end else begin
      wd_d = wd_q;
    end

    // Lockout sets on the owner's expiry and clears whenever that master's cyc is low.
    blk_d = cyc & (blk_q | ({sel, ~sel} & {2{expire}}));
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    // NOTE: non-blocking assignments so all registers update together on the
    // edge, independent of statement order.
    if (!wb_rst_n_i) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;  // m0 wins the first contention
      wd_q       <= 8'd0;
      blk_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      wd_q       <= wd_d;
      blk_q      <= blk_d;
    end
  end

  // Shared bus: combinational copy of the owner, quiet in IDLE and during expiry.
  assign bus.s_cyc_o = granted & (sel ? bus.m1_cyc_i : bus.m0_cyc_i) & ~expire;
  assign bus.s_stb_o = granted & (sel ? bus.m1_stb_i : bus.m0_stb_i) & ~expire;
  assign bus.s_we_o  = granted & (sel ? bus.m1_we_i  : bus.m0_we_i);
  assign bus.s_adr_o = !granted ? 16'h0000 : (sel ? bus.m1_adr_i : bus.m0_adr_i);
  assign bus.s_dat_o = !granted ? 8'h00    : (sel ? bus.m1_dat_i : bus.m0_dat_i);
  assign bus.s_tga_o = !granted ? 2'b00    : (sel ? bus.m1_tga_i : bus.m0_tga_i);

  // Only the owner sees ack, err and read data.
  assign bus.m0_ack_o = (state_q == GNT0) & bus.s_ack_i & bus.m0_stb_i;
  assign bus.m1_ack_o = (state_q == GNT1) & bus.s_ack_i & bus.m1_stb_i;
  assign bus.m0_err_o = (state_q == GNT0) & expire;
  assign bus.m1_err_o = (state_q == GNT1) & expire;
  assign bus.m0_dat_o = (state_q == GNT0) ? bus.s_dat_i : 8'h00;
  assign bus.m1_dat_o = (state_q == GNT1) ? bus.s_dat_i : 8'h00;

  assign bus.gnt_o = {state_q == GNT1, state_q == GNT0};

endmodule
